// File: rtl/baud_tick_gen_frac.sv
// rtl/baud_tick_gen_frac.sv - fractional-divisor TX/RX oversample tick generator

module baud_tick_chan #(
    parameter int DIV_INT_WIDTH  = 16,
    parameter int DIV_FRAC_WIDTH = 4,
    parameter int OVERSAMPLE     = 16,
    parameter int RESET_DIV_INT  = 27,
    parameter int RESET_DIV_FRAC = 2,
    localparam int SUB_WIDTH     = $clog2(OVERSAMPLE)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      resync,
    input  logic                      need_apply,
    input  logic [DIV_INT_WIDTH-1:0]  pend_int,
    input  logic [DIV_FRAC_WIDTH-1:0] pend_frac,
    output logic                      tick,
    output logic [SUB_WIDTH-1:0]      sub,
    output logic                      apply
);
    localparam logic [DIV_INT_WIDTH:0]   PER_ONE = 1;
    localparam logic [DIV_INT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [SUB_WIDTH-1:0]     SUB_ONE = 1;

    logic [DIV_INT_WIDTH-1:0]  cnt;
    logic [DIV_FRAC_WIDTH-1:0] acc;
    logic                      ext;
    logic [DIV_INT_WIDTH-1:0]  div_int;
    logic [DIV_FRAC_WIDTH-1:0] div_frac;
    logic [DIV_INT_WIDTH:0]    period;
    logic [DIV_FRAC_WIDTH:0]   acc_sum;
    logic                      at_end;

    // One extra bit so a maximal divisor plus the extend cycle cannot wrap.
    assign period  = {1'b0, div_int} + {{DIV_INT_WIDTH{1'b0}}, ext};
    assign at_end  = ({1'b0, cnt} + PER_ONE) == period;
    assign acc_sum = {1'b0, acc} + {1'b0, div_frac};
    assign tick    = enable && at_end && !resync && !reset;
    assign apply   = need_apply && (tick || !enable);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            ext      <= 1'b0;
            sub      <= '0;
            div_int  <= DIV_INT_WIDTH'(RESET_DIV_INT);
            div_frac <= DIV_FRAC_WIDTH'(RESET_DIV_FRAC);
        end else begin
            if (apply) begin
                div_int  <= pend_int;
                div_frac <= pend_frac;
            end
            if (resync) begin
                cnt <= '0;
                acc <= '0;
                ext <= 1'b0;
                sub <= '0;
            end else if (tick) begin
                cnt <= '0;
                {ext, acc} <= acc_sum;
                sub <= sub + SUB_ONE;
            end else if (enable) begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end
endmodule

module baud_tick_gen_frac #(
    parameter int DIV_INT_WIDTH  = 16,
    parameter int DIV_FRAC_WIDTH = 4,
    parameter int OVERSAMPLE     = 16,
    parameter int RESET_DIV_INT  = 27,
    parameter int RESET_DIV_FRAC = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DIV_INT_WIDTH-1:0]  cfg_div_int,
    input  logic [DIV_FRAC_WIDTH-1:0] cfg_div_frac,
    input  logic                      cfg_load,
    output logic                      cfg_err,
    output logic                      cfg_pending,
    input  logic                      tx_enable,
    input  logic                      rx_enable,
    input  logic                      rx_resync,
    output logic                      tx_tick,
    output logic                      rx_tick,
    output logic                      tx_bit_tick,
    output logic                      rx_sample
);
    localparam int SUB_WIDTH = $clog2(OVERSAMPLE);
    localparam logic [DIV_INT_WIDTH-1:0] MIN_DIV  = 2;
    localparam logic [SUB_WIDTH-1:0]     SUB_LAST = SUB_WIDTH'(OVERSAMPLE - 1);
    localparam logic [SUB_WIDTH-1:0]     SUB_MID  = SUB_WIDTH'(OVERSAMPLE / 2 - 1);

    logic [DIV_INT_WIDTH-1:0]  pend_int;
    logic [DIV_FRAC_WIDTH-1:0] pend_frac;
    logic                      tx_need;
    logic                      rx_need;
    logic                      tx_apply;
    logic                      rx_apply;
    logic [SUB_WIDTH-1:0]      tx_sub;
    logic [SUB_WIDTH-1:0]      rx_sub;
    logic                      load_ok;

    assign load_ok     = cfg_load && (cfg_div_int >= MIN_DIV);
    assign cfg_pending = tx_need || rx_need;

    // A load landing in the same cycle as an apply re-arms that channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_int  <= DIV_INT_WIDTH'(RESET_DIV_INT);
            pend_frac <= DIV_FRAC_WIDTH'(RESET_DIV_FRAC);
            tx_need   <= 1'b0;
            rx_need   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_load && (cfg_div_int < MIN_DIV);
            if (load_ok) begin
                pend_int  <= cfg_div_int;
                pend_frac <= cfg_div_frac;
            end
            tx_need <= load_ok || (tx_need && !tx_apply);
            rx_need <= load_ok || (rx_need && !rx_apply);
        end
    end

    baud_tick_chan #(
        .DIV_INT_WIDTH (DIV_INT_WIDTH),
        .DIV_FRAC_WIDTH(DIV_FRAC_WIDTH),
        .OVERSAMPLE    (OVERSAMPLE),
        .RESET_DIV_INT (RESET_DIV_INT),
        .RESET_DIV_FRAC(RESET_DIV_FRAC)
    ) u_tx (
        .clk       (clk),
        .reset     (reset),
        .enable    (tx_enable),
        .resync    (1'b0),
        .need_apply(tx_need),
        .pend_int  (pend_int),
        .pend_frac (pend_frac),
        .tick      (tx_tick),
        .sub       (tx_sub),
        .apply     (tx_apply)
    );

    baud_tick_chan #(
        .DIV_INT_WIDTH (DIV_INT_WIDTH),
        .DIV_FRAC_WIDTH(DIV_FRAC_WIDTH),
        .OVERSAMPLE    (OVERSAMPLE),
        .RESET_DIV_INT (RESET_DIV_INT),
        .RESET_DIV_FRAC(RESET_DIV_FRAC)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .enable    (rx_enable),
        .resync    (rx_resync),
        .need_apply(rx_need),
        .pend_int  (pend_int),
        .pend_frac (pend_frac),
        .tick      (rx_tick),
        .sub       (rx_sub),
        .apply     (rx_apply)
    );

    assign tx_bit_tick = tx_tick && (tx_sub == SUB_LAST);
    assign rx_sample   = rx_tick && (rx_sub == SUB_MID);
endmodule

// File: tb/tb_baud_tick_gen_frac.sv
// tb/tb_baud_tick_gen_frac.sv - scoreboard bench for baud_tick_gen_frac

module tb_baud_tick_gen_frac;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cfg_div_int = '0;
    logic [3:0]  cfg_div_frac = '0;
    logic        cfg_load = 1'b0;
    logic        cfg_err;
    logic        cfg_pending;
    logic        tx_enable = 1'b0;
    logic        rx_enable = 1'b0;
    logic        rx_resync = 1'b0;
    logic        tx_tick;
    logic        rx_tick;
    logic        tx_bit_tick;
    logic        rx_sample;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    q [5][$];
    string nm [5] = '{"tx_tick", "tx_bit_tick", "rx_tick", "rx_sample", "cfg_err"};

    baud_tick_gen_frac dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_div_int (cfg_div_int),
        .cfg_div_frac(cfg_div_frac),
        .cfg_load    (cfg_load),
        .cfg_err     (cfg_err),
        .cfg_pending (cfg_pending),
        .tx_enable   (tx_enable),
        .rx_enable   (rx_enable),
        .rx_resync   (rx_resync),
        .tx_tick     (tx_tick),
        .rx_tick     (rx_tick),
        .tx_bit_tick (tx_bit_tick),
        .rx_sample   (rx_sample)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor: each asserted strobe must match the oldest expected cycle.
    task automatic mon(input int i, input logic sig);
        int t;
        if (sig) begin
            checks++;
            if (q[i].size() == 0) begin
                errors++;
                $display("FAIL %s unexpected at cycle %0d, expected none", nm[i], cyc);
            end else begin
                t = q[i].pop_front();
                if (t != cyc) begin
                    errors++;
                    $display("FAIL %s seen at cycle %0d, expected cycle %0d", nm[i], cyc, t);
                end
            end
        end
        if (q[i].size() > 0 && q[i][0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s missing, now cycle %0d, expected cycle %0d", nm[i], cyc, q[i][0]);
            void'(q[i].pop_front());
        end
    endtask

    always @(negedge clk) begin
        mon(0, tx_tick);
        mon(1, tx_bit_tick);
        mon(2, rx_tick);
        mon(3, rx_sample);
        mon(4, cfg_err);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (q[i].size() != 0) begin
                errors++;
                $display("FAIL %s leftover %0d events, expected 0", nm[i], q[i].size());
                q[i].delete();
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tx_enable = 1'b0;
        rx_enable = 1'b0;
        cfg_load = 1'b0;
        rx_resync = 1'b0;
        step(1);
        chk("reset_outputs", {tx_tick, rx_tick, tx_bit_tick, rx_sample, cfg_err}, 0);
        chk("reset_pending", cfg_pending, 0);
        step(1);
        reset = 1'b0;
    endtask

    task automatic load_disabled(input int di, input int df);
        cfg_div_int = 16'(di);
        cfg_div_frac = 4'(df);
        cfg_load = 1'b1;
        step(1);
        cfg_load = 1'b0;
        chk("pending_after_load", cfg_pending, 1);
        step(1);
        chk("pending_applied_disabled", cfg_pending, 0);
    endtask

    initial begin
        int e;
        int t;
        int p;

        // Defaults 27 + 2/16: periods 27 with a 28 after every 8th tick.
        do_reset();
        e = cyc;
        tx_enable = 1'b1;
        t = e - 1;
        for (int k = 1; k <= 40; k++) begin
            p = (k > 1 && (k - 1) % 8 == 0) ? 28 : 27;
            t += p;
            q[0].push_back(t);
            if (k % 16 == 0) q[1].push_back(t);
        end
        wait_until(t + 2);
        tx_enable = 1'b0;
        drain();

        // 4 + 8/16 on both channels, plus a rejected load and a mid-run reload.
        do_reset();
        load_disabled(4, 8);
        e = cyc;
        tx_enable = 1'b1;
        rx_enable = 1'b1;
        t = e - 1;
        for (int k = 1; k <= 40; k++) begin
            p = (k >= 3 && k % 2 == 1) ? 5 : 4;
            t += p;
            q[0].push_back(t);
            q[2].push_back(t);
            if (k % 16 == 0) q[1].push_back(t);
            if (k % 16 == 8) q[3].push_back(t);
        end
        wait_until(e + 20);
        cfg_div_int = 16'd1;
        cfg_div_frac = 4'd3;
        cfg_load = 1'b1;
        q[4].push_back(e + 21);
        step(1);
        cfg_load = 1'b0;
        chk("pending_after_bad_load", cfg_pending, 0);
        step(1);
        chk("pending_after_bad_load_2", cfg_pending, 0);
        wait_until(e + 50);
        cfg_div_int = 16'd4;
        cfg_div_frac = 4'd8;
        cfg_load = 1'b1;
        step(1);
        cfg_load = 1'b0;
        wait_until(e + 52);
        chk("pending_before_tick", cfg_pending, 1);
        step(1);
        chk("pending_after_tick", cfg_pending, 0);
        wait_until(t + 2);
        tx_enable = 1'b0;
        rx_enable = 1'b0;
        drain();

        // Divisor 4, TX paused for 10 cycles while cnt holds 2.
        do_reset();
        load_disabled(4, 0);
        e = cyc;
        tx_enable = 1'b1;
        q[0].push_back(e + 3);
        q[0].push_back(e + 7);
        q[0].push_back(e + 11);
        q[0].push_back(e + 25);
        q[0].push_back(e + 29);
        q[0].push_back(e + 33);
        wait_until(e + 14);
        tx_enable = 1'b0;
        wait_until(e + 24);
        tx_enable = 1'b1;
        wait_until(e + 36);
        tx_enable = 1'b0;
        drain();

        // RX resync on a tick cycle: tick suppressed, sample mid start bit.
        do_reset();
        load_disabled(4, 0);
        e = cyc;
        rx_enable = 1'b1;
        q[2].push_back(e + 3);
        q[2].push_back(e + 7);
        for (int j = 0; j < 25; j++) q[2].push_back(e + 15 + 4 * j);
        q[3].push_back(e + 43);
        q[3].push_back(e + 107);
        wait_until(e + 11);
        rx_resync = 1'b1;
        step(1);
        rx_resync = 1'b0;
        wait_until(e + 114);
        rx_enable = 1'b0;
        drain();

        // Reset with a load pending discards it; default periods resume.
        do_reset();
        e = cyc;
        tx_enable = 1'b1;
        rx_enable = 1'b1;
        wait_until(e + 5);
        cfg_div_int = 16'd4;
        cfg_div_frac = 4'd8;
        cfg_load = 1'b1;
        step(1);
        cfg_load = 1'b0;
        chk("pending_before_reset", cfg_pending, 1);
        wait_until(e + 10);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("pending_after_reset", cfg_pending, 0);
        chk("outputs_after_reset", {tx_tick, rx_tick, tx_bit_tick, rx_sample, cfg_err}, 0);
        foreach (q[i]) if (i < 0) q[i].delete();
        for (int k = 0; k < 3; k++) begin
            q[0].push_back(e + 37 + 27 * k);
            q[2].push_back(e + 37 + 27 * k);
        end
        wait_until(e + 94);
        tx_enable = 1'b0;
        rx_enable = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/baud_tick_gen_frac.md
Name: baud_tick_gen_frac

Overview:
Second-generation baud tick generator for the APB-UART. It produces independent TX and RX oversampling ticks from a runtime-programmable fractional divisor, replacing a fixed compile-time divide. It also generates per-bit TX strobes and mid-bit RX sample strobes, and supports RX phase resynchronisation on start-bit detection. It sits between the APB register file (divisor programming) and the uart_tx / uart_rx engines.

Parameters:
DIV_INT_WIDTH, 16, width of integer divisor (cycles per oversample tick)
DIV_FRAC_WIDTH, 4, width of fractional divisor; fraction = cfg_div_frac / 2^DIV_FRAC_WIDTH
OVERSAMPLE, 16, oversample ticks per bit; power of two, >= 4
RESET_DIV_INT, 27, integer divisor active after reset (50 MHz / (115200*16) = 27.13)
RESET_DIV_FRAC, 2, fractional divisor active after reset (0.13*16 ≈ 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_div_int  in  DIV_INT_WIDTH  new integer divisor
cfg_div_frac  in  DIV_FRAC_WIDTH  new fractional divisor
cfg_load  in  1  one-cycle pulse; capture cfg_div_* into pending register
cfg_err  out  1  one-cycle pulse; load rejected (cfg_div_int < 2)
cfg_pending  out  1  high while a captured divisor is not yet applied to both channels
tx_enable  in  1  run TX tick chain
rx_enable  in  1  run RX tick chain
rx_resync  in  1  one-cycle pulse from RX start-bit detector; realign RX phase
tx_tick  out  1  TX oversample tick
rx_tick  out  1  RX oversample tick
tx_bit_tick  out  1  TX bit boundary, every OVERSAMPLE tx_ticks
rx_sample  out  1  RX mid-bit sample strobe

Behaviour:
- Reset (synchronous, sampled on clk rising edge): all outputs 0; active and pending divisors = RESET_DIV_INT/RESET_DIV_FRAC; all counters, fractional accumulators and sub-counters = 0; cfg_pending = 0.
- Each channel (TX, RX) is identical and independent. Each has:
  - Cycle counter cnt
  - Fraction accumulator acc (DIV_FRAC_WIDTH bits)
  - Extend flag ext
  - Sub-counter sub (log2(OVERSAMPLE) bits)
  - Its own copy of the active divisor
- Period: the current tick period is P = div_int + ext cycles. cnt counts 0..P-1 while enable=1. tick is asserted combinationally when enable && cnt == P-1. On that cycle:
  - cnt <= 0
  - {carry, acc} <= acc + div_frac
  - ext <= carry
  - sub <= sub + 1 (wraps)
- Long-term mean period = div_int + div_frac/2^DIV_FRAC_WIDTH cycles. With frac = 0, period is exactly div_int.
- enable=0: cnt, acc, ext and sub hold their values; tick = 0. Counting resumes from the held value when enable returns to 1. A tick cannot occur in a disabled cycle.
- First tick: from zeroed state with enable held high, the first tick occurs on the div_int-th enabled cycle (cycle index div_int-1).
- tx_bit_tick = tx_tick && tx_sub == OVERSAMPLE-1.
- rx_sample = rx_tick && rx_sub == OVERSAMPLE/2-1.
- rx_resync pulse: next cycle rx cnt, acc, ext and sub = 0, regardless of rx_enable. rx_tick is suppressed in the resync cycle. The first rx_sample therefore follows OVERSAMPLE/2 rx_ticks later (mid start bit).
- Simultaneous rx_resync and rx_tick: resync wins; no tick, no sample.
- Divisor load:
  - cfg_load with cfg_div_int >= 2: pending <= cfg_div_*, cfg_pending <= 1.
  - cfg_load with cfg_div_int < 2: pending unchanged; cfg_err pulses for 1 cycle, the cycle after cfg_load.
  - A later valid cfg_load overwrites pending, last write wins.
- Applying the pending divisor: each channel copies pending into its active divisor at its own next tick cycle, or on the next clock if that channel is disabled. The tick-cycle update takes effect for the following period. This guarantees no truncated or glitched period.
- cfg_pending clears once both channels have applied the latest pending value.
- rx_resync does not apply pending; only a tick or a disabled channel does.
- Reset mid-operation: all state returns to reset values on the next edge, including a pending divisor, which is discarded.
- Width rules: cnt is DIV_INT_WIDTH bits; the comparison uses DIV_INT_WIDTH+1 bits so that P = 2^DIV_INT_WIDTH-1+1 does not overflow. Fraction carry comes out of a DIV_FRAC_WIDTH+1-bit add.

Test Plan:
- Reset with defaults, tx_enable=1 for 2000 cycles -> tx_tick on cycles 26, 53, 80…; 16 ticks span 27*16+2 = 434 cycles; tx_bit_tick on every 16th tick.
- Load div_int=4, frac=8 (frac = 0.5), both enables held -> periods alternate 4,5,4,5; 32 ticks in exactly 144 cycles; cfg_pending drops after both channels tick.
- cfg_load div_int=1 -> cfg_err pulse 1 cycle; periods unchanged; cfg_pending stays 0.
- div_int=4, frac=0; drop tx_enable for 10 cycles at cnt=2 -> no tx_tick while low; next tick 2 enabled cycles after re-enable.
- div_int=4, frac=0, rx running; pulse rx_resync concurrent with an rx_tick -> no tick that cycle; rx_sample exactly 8*4 = 32 cycles after resync cycle; subsequent samples every 64 cycles.
- Assert reset mid-period with a load pending -> next cycle all outputs 0, cfg_pending 0; after release, periods match RESET_DIV_INT/RESET_DIV_FRAC.
